// File: rtl/instr_imm_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_imm_encoder_if
// Request / instruction-memory write bundle for instr_imm_encoder.
//
// Request side : flush, in_valid/in_ready, in_class, in_opc, in_rn, in_rt,
//                in_imm (64-bit signed immediate)
// Memory side  : mem_we, mem_addr, mem_wdata (encoded 32-bit instruction word)
// Status side  : done, status, err (sticky), full, wr_ptr
//
// master : program loader / test harness driving requests
// slave  : the encoder
// ---------------------------------------------------------------------------
interface instr_imm_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_class;
  logic [10:0]       in_opc;
  logic [4:0]        in_rn;
  logic [4:0]        in_rt;
  logic [63:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              done;
  logic [1:0]        status;
  logic              err;
  logic              full;
  logic [ADDR_W:0]   wr_ptr;

  modport master (
    output flush, in_valid, in_class, in_opc, in_rn, in_rt, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, done, status, err, full, wr_ptr
  );

  modport slave (
    input  flush, in_valid, in_class, in_opc, in_rn, in_rt, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata, done, status, err, full, wr_ptr
  );
endinterface

// File: rtl/instr_imm_encoder.sv
// ---------------------------------------------------------------------------
// instr_imm_encoder
// Packs an opcode, register fields and a 64-bit signed immediate into a
// 32-bit LEGv8 instruction word (B, CB, D formats), range-checks the
// immediate so that sign-extending the packed field gives back the original
// value, and writes accepted words to sequential instruction-memory addresses.
//
// Ports:
//   clk      : clock, all state updates on the rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : instr_imm_encoder_if.slave (request, memory write, status)
//
// Parameters:
//   ADDR_W   : instruction-memory word-address width
//   DEPTH    : number of writable words (DEPTH <= 2**ADDR_W)
//
// Optional feature (macro ENC_ROUNDTRIP_CHECK_EN):
//   Adds a VERIFY state after WRITE that re-extends the immediate field of
//   the written word and compares it with the captured immediate
//   (status 11 on mismatch). Without the macro there is no VERIFY state.
// ---------------------------------------------------------------------------
module instr_imm_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  instr_imm_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
`ifdef ENC_ROUNDTRIP_CHECK_EN
    S_WRITE,
    S_VERIFY
`else
    S_WRITE
`endif
  } state_t;

  localparam logic [1:0] CLS_B  = 2'b00;
  localparam logic [1:0] CLS_CB = 2'b10;
  localparam logic [1:0] CLS_D  = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_RANGE   = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b10;
`ifdef ENC_ROUNDTRIP_CHECK_EN
  localparam logic [1:0] ST_TRIP    = 2'b11;
`endif

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t            r_state;
  logic [1:0]        r_class;
  logic [10:0]       r_opc;
  logic [4:0]        r_rn;
  logic [4:0]        r_rt;
  logic [63:0]       r_imm;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_done;
  logic [1:0]        r_status;
  logic              r_err;
  logic [ADDR_W:0]   r_wr_ptr;

  logic              w_full;
  logic              w_ready;
  logic              w_illegal;
  logic              w_fits;
  logic [31:0]       w_packed;

  assign w_full  = (r_wr_ptr == LP_DEPTH);
  assign w_ready = (r_state == S_IDLE) && !w_full;

  // Format legality, range check and packing from the captured request.
  // The class code doubles as the expected value of opc[10:9].
  // A field fits when every bit above its sign bit equals the sign bit.
  always_comb begin
    w_illegal = (r_class == 2'b01) || (r_opc[10:9] != r_class);
    w_fits    = 1'b0;
    w_packed  = '0;
    case (r_class)
      CLS_B: begin
        w_fits   = (&r_imm[63:25]) || !(|r_imm[63:25]);
        w_packed = {r_opc[10:5], r_imm[25:0]};
      end
      CLS_CB: begin
        w_fits   = (&r_imm[63:18]) || !(|r_imm[63:18]);
        w_packed = {r_opc[10:3], r_imm[18:0], r_rt};
      end
      CLS_D: begin
        w_fits   = (&r_imm[63:8]) || !(|r_imm[63:8]);
        w_packed = {r_opc, r_imm[8:0], 2'b00, r_rn, r_rt};
      end
      default: ;
    endcase
  end

`ifdef ENC_ROUNDTRIP_CHECK_EN
  logic [63:0] w_reext;

  // Sign-extend the immediate field back out of the word actually written,
  // so the comparison covers the packing path end to end.
  always_comb begin
    w_reext = '0;
    case (r_class)
      CLS_B:   w_reext = {{38{r_mem_wdata[25]}}, r_mem_wdata[25:0]};
      CLS_CB:  w_reext = {{45{r_mem_wdata[23]}}, r_mem_wdata[23:5]};
      CLS_D:   w_reext = {{55{r_mem_wdata[20]}}, r_mem_wdata[20:12]};
      default: w_reext = '0;
    endcase
  end
`endif

  // Controller: capture in IDLE, decide in CHECK, strobe the write in WRITE.
  // flush outranks everything and drops any in-flight request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_class     <= '0;
      r_opc       <= '0;
      r_rn        <= '0;
      r_rt        <= '0;
      r_imm       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_status    <= ST_OK;
      r_err       <= 1'b0;
      r_wr_ptr    <= '0;
    end else if (bus.flush) begin
      r_state  <= S_IDLE;
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_wr_ptr <= '0;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && w_ready) begin
            r_class <= bus.in_class;
            r_opc   <= bus.in_opc;
            r_rn    <= bus.in_rn;
            r_rt    <= bus.in_rt;
            r_imm   <= bus.in_imm;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_illegal) begin
            r_done   <= 1'b1;
            r_status <= ST_ILLEGAL;
            r_err    <= 1'b1;
            r_state  <= S_IDLE;
          end else if (!w_fits) begin
            r_done   <= 1'b1;
            r_status <= ST_RANGE;
            r_err    <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_wr_ptr[ADDR_W-1:0];
            r_mem_wdata <= w_packed;
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
`ifdef ENC_ROUNDTRIP_CHECK_EN
          r_state  <= S_VERIFY;
`else
          r_done   <= 1'b1;
          r_status <= ST_OK;
          r_state  <= S_IDLE;
`endif
        end
`ifdef ENC_ROUNDTRIP_CHECK_EN
        S_VERIFY: begin
          r_done <= 1'b1;
          if (w_reext == r_imm) begin
            r_status <= ST_OK;
          end else begin
            r_status <= ST_TRIP;
            r_err    <= 1'b1;
          end
          r_state <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes are masked by flush so a flush in WRITE or on the done cycle
  // suppresses them in that same cycle; in_ready stays low during reset.
  assign bus.in_ready  = reset_n && w_ready;
  assign bus.mem_we    = r_mem_we && !bus.flush;
  assign bus.done      = r_done && !bus.flush;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.status    = r_status;
  assign bus.err       = r_err;
  assign bus.full      = w_full;
  assign bus.wr_ptr    = r_wr_ptr;

endmodule
